traffic_phase_sequencer: RTL and testbench
==========================================

Name: traffic_phase_sequencer

Overview:
Parametrised traffic-light phase sequencer that cycles through NUM_PHASES programmable LED patterns. Each green interval is followed by a blinking clearance interval. The block adds a hold switch, a manual-step mode driven by a raw push-button, and a one-shot green-extension request. It sits between the board switches/buttons and the LED bank, and supersedes the fixed four-state, fixed-timer light controller.

Parameters:
TICKS_PER_SEC, 100_000_000, clock cycles per one-second tick (benches override with a small value)
NUM_PHASES, 4, number of phases; legal range 2..8
LED_W, 16, LED output width
GREEN_SEC, 5, green duration per phase, in seconds (>=1)
CLEAR_SEC, 1, clearance duration, in seconds (>=1)
EXT_SEC, 3, seconds added by an accepted extension request
PATTERNS, {16'h000E,16'h0E00,16'h2020,16'hC0C0}, NUM_PHASES*LED_W bits; phase k pattern = PATTERNS[k*LED_W +: LED_W]

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
hold  input  1  level; freezes the prescaler and timers while high
manual  input  1  level; 1 = green ends only on step button, never on timeout
step_btn  input  1  raw asynchronous button; ends green in manual mode
ext_req  input  1  raw asynchronous button; requests a green extension
led  output  LED_W  registered light pattern
phase  output  3  registered current phase index
in_clear  output  1  registered; high during clearance
phase_done  output  1  one-cycle pulse when clearance ends

Behaviour:
- Reset (asynchronous, active-high) forces the following:
  - led=0, phase=0, in_clear=0, phase_done=0.
  - FSM=GREEN, sec_left=GREEN_SEC, prescaler=0, ext_used=0.
  - Both synchroniser chains cleared.
- Outputs are registered from the state, so they lag the state by one cycle. led shows PATTERNS phase 0 on the first edge after rst deasserts.
- Inputs step_btn and ext_req:
  - Each passes through a 2-flop synchroniser plus a rising-edge detect, giving one internal pulse per press.
  - Latency from input rise to internal pulse is 3 clk edges. Holding the button high yields a single pulse.
  - No debounce is applied; pulses are spaced by the bench.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 and emits tick on the terminal count.
  - Resets to 0 on every state entry, so intervals are exact multiples of TICKS_PER_SEC.
  - Frozen while hold=1.
- FSM states: GREEN and CLEAR.
- GREEN:
  - led=pattern[phase], in_clear=0.
  - Each tick decrements sec_left.
  - If manual=0 and tick arrives with sec_left==1, go to CLEAR and load sec_left=CLEAR_SEC.
  - If manual=1, sec_left stops decrementing at 1. The step pulse goes to CLEAR, including while hold=1.
  - An ext_req pulse while ext_used=0 adds EXT_SEC to sec_left (8-bit, saturating at 255) and sets ext_used=1. Further requests in the same phase are ignored.
  - Tick on the last second and ext_req in the same cycle: extension wins, so the phase stays GREEN with sec_left = 1-1+EXT_SEC = EXT_SEC.
- CLEAR:
  - in_clear=1. led=pattern[phase] while prescaler < TICKS_PER_SEC/2, else 0; this is a 1 Hz blink.
  - The step pulse is ignored in CLEAR, as is ext_req.
  - The transition out of CLEAR applies in both modes and is frozen only by hold.
  - On tick with sec_left==1, the following all happen:
    - go to GREEN;
    - phase increments, wrapping from NUM_PHASES-1 to 0;
    - sec_left=GREEN_SEC, ext_used=0;
    - phase_done pulses for one cycle, aligned with the phase output update.
- Hold:
  - Freezes all timing state but not the outputs.
  - Releasing hold resumes from the frozen prescaler value with no lost or extra cycles.
- Mode switch mid-phase: changing manual from 1 to 0 in GREEN with sec_left==1 ends green on the next tick.
- Reset asserted mid-interval returns everything to the reset state immediately.

Test Plan:
1. Free-run (TICKS_PER_SEC=10, GREEN_SEC=3, CLEAR_SEC=1, NUM_PHASES=4): release rst -> led=16'hC0C0 for 30 cycles; then in_clear=1 for 10 cycles with led alternating C0C0/0000 every 5 cycles; then phase_done pulse, phase=1, led=16'h2020; phase 3 wraps to phase 0 after 160 cycles total.
2. Extension: ext_req high for 20 cycles during phase 0 green -> green lasts (3+3)*10=60 cycles. A second press in the same phase -> no change. A press in phase 1 green -> accepted again.
3. Manual: manual=1 -> phase 0 green persists for more than 100 cycles. step_btn press -> in_clear rises 4 edges after the button rises. A step press during CLEAR -> ignored, and clearance still lasts 10 cycles.
4. Hold: assert hold 15 cycles into phase 0 green for 50 cycles -> green ends at cycle 30+50, with outputs static during the hold. A step press during hold in manual mode -> enters CLEAR, and the clearance stays frozen until hold drops.
5. Boundary collision: ext_req timed so its internal pulse coincides with the final green tick -> phase stays GREEN for a further 3 seconds (30 cycles).
6. Reset mid-CLEAR of phase 2 (async, between edges) -> led=0, phase=0, in_clear=0 immediately; the normal phase 0 sequence restarts after release.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Traffic-light phase sequencer: programmable per-phase LED patterns, timed green,
// blinking clearance, plus hold, manual step and one-shot green extension.
module traffic_phase_sequencer #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int NUM_PHASES    = 4,
  parameter int LED_W         = 16,
  parameter int GREEN_SEC     = 5,
  parameter int CLEAR_SEC     = 1,
  parameter int EXT_SEC       = 3,
  parameter logic [NUM_PHASES*LED_W-1:0] PATTERNS = {16'h000E, 16'h0E00, 16'h2020, 16'hC0C0}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             manual,
  input  logic             step_btn,
  input  logic             ext_req,
  output logic [LED_W-1:0] led,
  output logic [2:0]       phase,
  output logic             in_clear,
  output logic             phase_done
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICKS_PER_SEC / 2);
  localparam logic [2:0]    LAST_PHASE = 3'(NUM_PHASES - 1);

  typedef enum logic {GREEN, CLEAR} state_e;

  state_e          state_q, state_d;
  logic [2:0]      phase_q, phase_d;
  logic [7:0]      secLeft_q, secLeft_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            extUsed_q, extUsed_d;
  logic            wrap_q, wrap_d;
  logic [2:0]      stepSync_q, extSync_q;
  logic            stepPulse, extPulse, tick, extAccept, decGreen;
  logic [9:0]      secSum;
  logic [LED_W-1:0] patTable [8];

  // Unused table slots read as dark so the index can stay a plain 3-bit phase.
  for (genvar k = 0; k < 8; k++) begin : gPat
    if (k < NUM_PHASES) begin : gUsed
      assign patTable[k] = PATTERNS[k*LED_W +: LED_W];
    end else begin : gUnused
      assign patTable[k] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stepSync_q <= '0;
      extSync_q  <= '0;
    end else begin
      stepSync_q <= {stepSync_q[1:0], step_btn};
      extSync_q  <= {extSync_q[1:0], ext_req};
    end
  end

  assign stepPulse = stepSync_q[1] & ~stepSync_q[2];
  assign extPulse  = extSync_q[1] & ~extSync_q[2];
  assign tick      = !hold && (presc_q == PRESC_LAST);
  assign extAccept = (state_q == GREEN) && extPulse && !extUsed_q;
  assign decGreen  = tick && (!manual || secLeft_q > 8'd1);
  // Extension and final-second decrement combine, so a collision leaves EXT_SEC.
  assign secSum    = {2'b00, secLeft_q} + (extAccept ? 10'(EXT_SEC) : 10'd0)
                     - (decGreen ? 10'd1 : 10'd0);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    secLeft_d = secLeft_q;
    presc_d   = presc_q;
    extUsed_d = extUsed_q;
    wrap_d    = 1'b0;
    if (!hold) presc_d = tick ? '0 : presc_q + PW'(1);
    case (state_q)
      GREEN: begin
        secLeft_d = (secSum > 10'd255) ? 8'hFF : secSum[7:0];
        if (extAccept) extUsed_d = 1'b1;
        if ((manual && stepPulse) ||
            (!manual && tick && secLeft_q == 8'd1 && !extAccept)) begin
          state_d   = CLEAR;
          secLeft_d = 8'(CLEAR_SEC);
          presc_d   = '0;
        end
      end
      CLEAR: begin
        if (tick) begin
          if (secLeft_q == 8'd1) begin
            state_d   = GREEN;
            phase_d   = (phase_q == LAST_PHASE) ? 3'd0 : phase_q + 3'd1;
            secLeft_d = 8'(GREEN_SEC);
            extUsed_d = 1'b0;
            presc_d   = '0;
            wrap_d    = 1'b1;
          end else begin
            secLeft_d = secLeft_q - 8'd1;
          end
        end
      end
      default: state_d = GREEN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= GREEN;
      phase_q   <= 3'd0;
      secLeft_q <= 8'(GREEN_SEC);
      presc_q   <= '0;
      extUsed_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      secLeft_q <= secLeft_d;
      presc_q   <= presc_d;
      extUsed_q <= extUsed_d;
      wrap_q    <= wrap_d;
    end
  end

  // Outputs follow the state one cycle later; phase_done lines up with the phase change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led        <= '0;
      phase      <= 3'd0;
      in_clear   <= 1'b0;
      phase_done <= 1'b0;
    end else begin
      led        <= (state_q == GREEN || presc_q < PRESC_HALF) ? patTable[phase_q] : '0;
      phase      <= phase_q;
      in_clear   <= (state_q == CLEAR);
      phase_done <= wrap_q;
    end
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with a 10-cycle second, 3 s green, 1 s clear.
module tb_traffic_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        manual = 1'b0;
  logic        step_btn = 1'b0;
  logic        ext_req = 1'b0;
  logic [15:0] led;
  logic [2:0]  phase;
  logic        in_clear;
  logic        phase_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  traffic_phase_sequencer #(
    .TICKS_PER_SEC(10),
    .NUM_PHASES(4),
    .LED_W(16),
    .GREEN_SEC(3),
    .CLEAR_SEC(1),
    .EXT_SEC(3),
    .PATTERNS({16'h000E, 16'h0E00, 16'h2020, 16'hC0C0})
  ) dut (
    .clk(clk),
    .rst(rst),
    .hold(hold),
    .manual(manual),
    .step_btn(step_btn),
    .ext_req(ext_req),
    .led(led),
    .phase(phase),
    .in_clear(in_clear),
    .phase_done(phase_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, observed, expected);
    end
  endtask

  // cyc counts rising edges since reset release; sampling happens on the falling edge.
  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic runTo(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    $display("[TB] free-run sequence");
    doReset();
    checkOutput("rst_led", 32'(led), 32'h0);
    checkOutput("rst_phase", 32'(phase), 32'd0);
    checkOutput("rst_clear", 32'(in_clear), 32'd0);
    checkOutput("rst_done", 32'(phase_done), 32'd0);
    runTo(1);   checkOutput("fr_led1", 32'(led), 32'hC0C0);
    runTo(30);  checkOutput("fr_green_end", 32'(in_clear), 32'd0);
    checkOutput("fr_led30", 32'(led), 32'hC0C0);
    runTo(31);  checkOutput("fr_clear_start", 32'(in_clear), 32'd1);
    runTo(35);  checkOutput("fr_blink_on", 32'(led), 32'hC0C0);
    runTo(36);  checkOutput("fr_blink_off", 32'(led), 32'h0);
    runTo(40);  checkOutput("fr_clear_last", 32'(in_clear), 32'd1);
    checkOutput("fr_done_early", 32'(phase_done), 32'd0);
    runTo(41);  checkOutput("fr_phase1", 32'(phase), 32'd1);
    checkOutput("fr_led_p1", 32'(led), 32'h2020);
    checkOutput("fr_done_p1", 32'(phase_done), 32'd1);
    runTo(42);  checkOutput("fr_done_oneshot", 32'(phase_done), 32'd0);
    runTo(81);  checkOutput("fr_led_p2", 32'(led), 32'h0E00);
    runTo(121); checkOutput("fr_led_p3", 32'(led), 32'h000E);
    checkOutput("fr_phase3", 32'(phase), 32'd3);
    runTo(160); checkOutput("fr_phase3_end", 32'(phase), 32'd3);
    runTo(161); checkOutput("fr_wrap_phase", 32'(phase), 32'd0);
    checkOutput("fr_wrap_led", 32'(led), 32'hC0C0);
    checkOutput("fr_wrap_done", 32'(phase_done), 32'd1);

    $display("[TB] extension requests");
    doReset();
    runTo(5);   ext_req = 1'b1;
    runTo(25);  ext_req = 1'b0;
    runTo(31);  checkOutput("ext_no_clear31", 32'(in_clear), 32'd0);
    runTo(35);  ext_req = 1'b1;
    runTo(38);  ext_req = 1'b0;
    runTo(60);  checkOutput("ext_green60", 32'(in_clear), 32'd0);
    runTo(61);  checkOutput("ext_clear61", 32'(in_clear), 32'd1);
    runTo(71);  checkOutput("ext_phase1", 32'(phase), 32'd1);
    runTo(75);  ext_req = 1'b1;
    runTo(78);  ext_req = 1'b0;
    runTo(101); checkOutput("ext_p1_extended", 32'(in_clear), 32'd0);
    runTo(130); checkOutput("ext_p1_green130", 32'(in_clear), 32'd0);
    runTo(131); checkOutput("ext_p1_clear131", 32'(in_clear), 32'd1);

    $display("[TB] boundary collision");
    doReset();
    runTo(27);  ext_req = 1'b1;
    runTo(31);  checkOutput("col_stay_green", 32'(in_clear), 32'd0);
    runTo(32);  ext_req = 1'b0;
    runTo(60);  checkOutput("col_green60", 32'(in_clear), 32'd0);
    runTo(61);  checkOutput("col_clear61", 32'(in_clear), 32'd1);

    $display("[TB] manual mode");
    manual = 1'b1;
    doReset();
    runTo(120); checkOutput("man_persist", 32'(in_clear), 32'd0);
    checkOutput("man_led", 32'(led), 32'hC0C0);
    runTo(125); step_btn = 1'b1;
    runTo(128); checkOutput("man_latency3", 32'(in_clear), 32'd0);
    runTo(129); checkOutput("man_latency4", 32'(in_clear), 32'd1);
    runTo(130); step_btn = 1'b0;
    runTo(131); step_btn = 1'b1;
    runTo(133); step_btn = 1'b0;
    runTo(138); checkOutput("man_clear_full", 32'(in_clear), 32'd1);
    checkOutput("man_clear_phase", 32'(phase), 32'd0);
    runTo(139); checkOutput("man_next_phase", 32'(phase), 32'd1);
    checkOutput("man_next_done", 32'(phase_done), 32'd1);
    runTo(200); checkOutput("man_p1_persist", 32'(in_clear), 32'd0);
    manual = 1'b0;
    runTo(208); checkOutput("mode_sw_green", 32'(in_clear), 32'd0);
    runTo(209); checkOutput("mode_sw_clear", 32'(in_clear), 32'd1);

    $display("[TB] hold");
    doReset();
    runTo(15);  hold = 1'b1;
    runTo(50);  checkOutput("hold_led", 32'(led), 32'hC0C0);
    checkOutput("hold_clear", 32'(in_clear), 32'd0);
    runTo(65);  hold = 1'b0;
    runTo(80);  checkOutput("hold_green80", 32'(in_clear), 32'd0);
    runTo(81);  checkOutput("hold_clear81", 32'(in_clear), 32'd1);

    $display("[TB] step during hold");
    manual = 1'b1;
    doReset();
    runTo(15);  hold = 1'b1;
    runTo(20);  step_btn = 1'b1;
    runTo(24);  checkOutput("hstep_clear", 32'(in_clear), 32'd1);
    runTo(25);  step_btn = 1'b0;
    runTo(59);  checkOutput("hstep_frozen", 32'(in_clear), 32'd1);
    checkOutput("hstep_led", 32'(led), 32'hC0C0);
    checkOutput("hstep_phase", 32'(phase), 32'd0);
    runTo(60);  hold = 1'b0;
    runTo(70);  checkOutput("hstep_clear70", 32'(in_clear), 32'd1);
    runTo(71);  checkOutput("hstep_phase1", 32'(phase), 32'd1);
    checkOutput("hstep_green71", 32'(in_clear), 32'd0);
    manual = 1'b0;

    $display("[TB] reset during clearance");
    doReset();
    runTo(113); checkOutput("mid_clear", 32'(in_clear), 32'd1);
    checkOutput("mid_phase2", 32'(phase), 32'd2);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_led", 32'(led), 32'h0);
    checkOutput("async_phase", 32'(phase), 32'd0);
    checkOutput("async_clear", 32'(in_clear), 32'd0);
    doReset();
    runTo(1);   checkOutput("restart_led", 32'(led), 32'hC0C0);
    runTo(30);  checkOutput("restart_green", 32'(in_clear), 32'd0);
    runTo(31);  checkOutput("restart_clear", 32'(in_clear), 32'd1);
    runTo(41);  checkOutput("restart_phase1", 32'(phase), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
